// File: rtl/ram_readback_checker.sv
// ram_readback_checker: sweeps a synchronous-read RAM, compares every word
// against (addr + seed), counts mismatches and reports status on the LEDs.
module ram_readback_checker #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 1,
  parameter int ERR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              locked,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [7:0]        led_o
);

  localparam int DCW = $clog2(RD_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t state, state_n;

  // Stage 0 is the issue stage (it drives rd_en/rd_addr); stage RD_LATENCY
  // lines up with the returning rd_data.
  logic [RD_LATENCY:0]             vld_pipe;
  logic [RD_LATENCY:0][ADDR_W-1:0] addr_pipe;

  logic [DATA_W-1:0] seed_q;
  logic [DCW-1:0]    drain_cnt;
  logic              accept, last_addr, drain_end, mismatch;
  logic [DATA_W-1:0] exp_data;
  logic [3:0]        err_sat4;

  assign accept    = start && locked && (state == IDLE || state == DONE);
  assign last_addr = &addr_pipe[0];
  assign drain_end = (drain_cnt == DCW'(RD_LATENCY - 1));
  assign exp_data  = DATA_W'(addr_pipe[RD_LATENCY]) + seed_q;
  assign mismatch  = vld_pipe[RD_LATENCY] && locked && (rd_data != exp_data);

  assign rd_en   = vld_pipe[0];
  assign rd_addr = addr_pipe[0];

  // Next-state logic; losing lock overrides everything except reset.
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: if (accept)    state_n = READ;
      READ:       if (last_addr) state_n = DRAIN;
      DRAIN:      if (drain_end) state_n = DONE;
      default:                   state_n = IDLE;
    endcase
    if (!locked) state_n = IDLE;
  end

  // State register, registered status flags, address counter and valid/address pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      drain_cnt <= '0;
      vld_pipe  <= '0;
      addr_pipe <= '0;
    end else begin
      state       <= state_n;
      busy        <= (state_n == READ) || (state_n == DRAIN);
      done        <= (state_n == DONE);
      drain_cnt   <= (state == DRAIN) ? drain_cnt + DCW'(1) : '0;
      vld_pipe[0] <= (state_n == READ);
      if (accept)
        addr_pipe[0] <= '0;
      else if (state == READ && !last_addr)
        addr_pipe[0] <= addr_pipe[0] + ADDR_W'(1);
      for (int i = 1; i <= RD_LATENCY; i++) begin
        vld_pipe[i]  <= locked ? vld_pipe[i-1] : 1'b0;
        addr_pipe[i] <= addr_pipe[i-1];
      end
    end
  end

  // Seed capture and saturating mismatch bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      seed_q         <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else if (accept) begin
      seed_q         <= seed;
      err_count      <= '0;
      first_err_addr <= '0;
    end else if (mismatch) begin
      if (err_count != '1)
        err_count <= err_count + ERR_W'(1);
      if (err_count == '0)
        first_err_addr <= addr_pipe[RD_LATENCY];
    end
  end

  // LED status is derived combinationally from the registered flags.
  always_comb begin
    err_sat4 = (err_count > ERR_W'(15)) ? 4'hF : err_count[3:0];
    pass     = done && (err_count == '0);
    led_o    = {err_sat4, done && !pass, pass, done, busy};
  end

endmodule

// File: tb/tb_ram_readback_checker.sv
// Directed bench: three checker instances (latency 1, latency 3, tiny
// saturating counter) each reading a behavioural RAM model.
module tb_ram_readback_checker;

  logic clk = 1'b0;
  logic rst, locked;

  // Instance A: defaults (ADDR_W=10, RD_LATENCY=1, ERR_W=16)
  logic        start_a, rd_en_a, busy_a, done_a, pass_a;
  logic [7:0]  seed_a, rd_data_a, led_a;
  logic [9:0]  rd_addr_a, fe_a;
  logic [15:0] err_a;
  // Instance B: RD_LATENCY=3
  logic        start_b, rd_en_b, busy_b, done_b, pass_b;
  logic [7:0]  seed_b, rd_data_b, led_b, b_d1, b_d2;
  logic [9:0]  rd_addr_b, fe_b;
  logic [15:0] err_b;
  // Instance C: ADDR_W=5, ERR_W=4
  logic        start_c, rd_en_c, busy_c, done_c, pass_c;
  logic [7:0]  seed_c, rd_data_c, led_c;
  logic [4:0]  rd_addr_c, fe_c;
  logic [3:0]  err_c;

  logic [7:0] mem_a [0:1023];
  logic [7:0] mem_b [0:1023];
  logic [7:0] mem_c [0:31];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_readback_checker u_a (
    .clk(clk), .rst(rst), .locked(locked), .start(start_a), .seed(seed_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .busy(busy_a),
    .done(done_a), .pass(pass_a), .err_count(err_a), .first_err_addr(fe_a),
    .led_o(led_a));

  ram_readback_checker #(.RD_LATENCY(3)) u_b (
    .clk(clk), .rst(rst), .locked(locked), .start(start_b), .seed(seed_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .busy(busy_b),
    .done(done_b), .pass(pass_b), .err_count(err_b), .first_err_addr(fe_b),
    .led_o(led_b));

  ram_readback_checker #(.ADDR_W(5), .ERR_W(4)) u_c (
    .clk(clk), .rst(rst), .locked(locked), .start(start_c), .seed(seed_c),
    .rd_en(rd_en_c), .rd_addr(rd_addr_c), .rd_data(rd_data_c), .busy(busy_c),
    .done(done_c), .pass(pass_c), .err_count(err_c), .first_err_addr(fe_c),
    .led_o(led_c));

  // RAM models: latency 1 for A and C, latency 3 for B
  always @(posedge clk) if (rd_en_a) rd_data_a <= mem_a[rd_addr_a];
  always @(posedge clk) if (rd_en_c) rd_data_c <= mem_c[rd_addr_c];
  always @(posedge clk) begin
    if (rd_en_b) b_d1 <= mem_b[rd_addr_b];
    b_d2      <= b_d1;
    rd_data_b <= b_d2;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_a(input logic [7:0] s, input int bad0, input int bad1);
    for (int i = 0; i < 1024; i++) begin
      mem_a[i] = 8'(i) + s;
      if (i == bad0 || i == bad1) mem_a[i] = mem_a[i] ^ 8'h01;
    end
  endtask

  task automatic fill_b(input logic [7:0] s, input int bad0);
    for (int i = 0; i < 1024; i++) begin
      mem_b[i] = 8'(i) + s;
      if (i == bad0) mem_b[i] = mem_b[i] ^ 8'h01;
    end
  endtask

  task automatic drive_start(input int sel, input logic v, input logic [7:0] s);
    case (sel)
      0:       begin start_a = v; seed_a = s; end
      1:       begin start_b = v; seed_b = s; end
      default: begin start_c = v; seed_c = s; end
    endcase
  endtask

  function automatic logic get_done(input int sel);
    case (sel)
      0:       return done_a;
      1:       return done_b;
      default: return done_c;
    endcase
  endfunction

  // Accept a start, then count cycles until done; optionally re-pulse start
  // (with a different seed) at cycle 'poke' while the sweep is busy.
  task automatic sweep(input int sel, input logic [7:0] s, input int poke, output int cyc);
    drive_start(sel, 1'b1, s);
    tick;
    drive_start(sel, 1'b0, s);
    cyc = 1;
    while (!get_done(sel) && cyc < 1200) begin
      if (cyc == poke) drive_start(sel, 1'b1, s ^ 8'hFF);
      tick;
      drive_start(sel, 1'b0, s);
      cyc++;
    end
    chk("sweep_done", 32'(get_done(sel)), 32'd1);
  endtask

  initial begin
    int   cyc;
    logic seq_ok;
    rst = 1'b1; locked = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    seed_a = 8'h00; seed_b = 8'h00; seed_c = 8'h00;
    tick; tick;

    // Reset state
    chk("rst_rd_en",  32'(rd_en_a),   32'd0);
    chk("rst_rd_addr",32'(rd_addr_a), 32'd0);
    chk("rst_busy",   32'(busy_a),    32'd0);
    chk("rst_done",   32'(done_a),    32'd0);
    chk("rst_pass",   32'(pass_a),    32'd0);
    chk("rst_err",    32'(err_a),     32'd0);
    chk("rst_fe",     32'(fe_a),      32'd0);
    chk("rst_led_a",  32'(led_a),     32'd0);
    chk("rst_led_b",  32'(led_b),     32'd0);
    chk("rst_led_c",  32'(led_c),     32'd0);
    rst = 1'b0; locked = 1'b1;
    tick;

    // A: clean memory, seed 0x5A, exact cycle-by-cycle timing
    fill_a(8'h5A, -1, -1);
    start_a = 1'b1; seed_a = 8'h5A;
    tick;                              // edge 0
    start_a = 1'b0; seed_a = 8'h00;
    chk("A_c1_rd_en", 32'(rd_en_a),   32'd1);
    chk("A_c1_addr",  32'(rd_addr_a), 32'd0);
    chk("A_c1_busy",  32'(busy_a),    32'd1);
    seq_ok = 1'b1;
    for (int k = 1; k < 1024; k++) begin
      tick;
      if (rd_addr_a !== 10'(k) || rd_en_a !== 1'b1) seq_ok = 1'b0;
    end
    chk("A_addr_seq", 32'(seq_ok), 32'd1);
    tick;                              // cycle 1025: draining
    chk("A_c1025_rd_en", 32'(rd_en_a), 32'd0);
    chk("A_c1025_busy",  32'(busy_a),  32'd1);
    chk("A_c1025_done",  32'(done_a),  32'd0);
    chk("A_c1025_pass",  32'(pass_a),  32'd0);
    tick;                              // cycle 1026: done
    chk("A_done", 32'(done_a), 32'd1);
    chk("A_busy", 32'(busy_a), 32'd0);
    chk("A_err",  32'(err_a),  32'd0);
    chk("A_pass", 32'(pass_a), 32'd1);
    chk("A_led",  32'(led_a),  32'h06);

    // B: corrupt 5 and 700, seed 0, restart directly from DONE
    fill_a(8'h00, 5, 700);
    sweep(0, 8'h00, -1, cyc);
    chk("B_cycles", 32'(cyc),    32'd1026);
    chk("B_err",    32'(err_a),  32'd2);
    chk("B_fe",     32'(fe_a),   32'd5);
    chk("B_pass",   32'(pass_a), 32'd0);
    chk("B_led",    32'(led_a),  32'h2A);

    // C: every word wrong, 4-bit counter must saturate at 15
    for (int i = 0; i < 32; i++) mem_c[i] = (8'(i) + 8'h33) ^ 8'h80;
    sweep(2, 8'h33, -1, cyc);
    chk("C_cycles", 32'(cyc),       32'd34);
    chk("C_err",    32'(err_c),     32'd15);
    chk("C_fe",     32'(fe_c),      32'd0);
    chk("C_led_hi", 32'(led_c[7:4]),32'hF);
    chk("C_fail",   32'(led_c[3]),  32'd1);
    chk("C_led",    32'(led_c),     32'hFA);

    // D: latency 3, seed 0xFF (addr 1 expects 0x00), then corrupt last address
    fill_b(8'hFF, -1);
    sweep(1, 8'hFF, -1, cyc);
    chk("D_cycles", 32'(cyc),    32'd1028);
    chk("D_err",    32'(err_b),  32'd0);
    chk("D_pass",   32'(pass_b), 32'd1);
    fill_b(8'hFF, 1023);
    sweep(1, 8'hFF, -1, cyc);
    chk("D2_cycles", 32'(cyc),    32'd1028);
    chk("D2_err",    32'(err_b),  32'd1);
    chk("D2_fe",     32'(fe_b),   32'd1023);
    chk("D2_pass",   32'(pass_b), 32'd0);

    // E1: start (with another seed) pulsed mid-sweep is ignored
    fill_a(8'h5A, -1, -1);
    sweep(0, 8'h5A, 200, cyc);
    chk("E1_cycles", 32'(cyc),    32'd1026);
    chk("E1_err",    32'(err_a),  32'd0);
    chk("E1_pass",   32'(pass_a), 32'd1);

    // E2: lock lost at cycle 300 aborts; counts keep their values
    fill_a(8'h00, 5, 700);
    start_a = 1'b1; seed_a = 8'h00;
    tick;
    start_a = 1'b0;
    repeat (299) tick;                 // cycle 300
    chk("E2_pre_err", 32'(err_a), 32'd1);
    locked = 1'b0;
    tick;
    chk("E2_rd_en", 32'(rd_en_a), 32'd0);
    chk("E2_busy",  32'(busy_a),  32'd0);
    chk("E2_done",  32'(done_a),  32'd0);
    repeat (1100) tick;
    chk("E2_err_hold", 32'(err_a),  32'd1);
    chk("E2_fe_hold",  32'(fe_a),   32'd5);
    chk("E2_done_lo",  32'(done_a), 32'd0);
    chk("E2_pass_lo",  32'(pass_a), 32'd0);
    start_a = 1'b1;
    tick;
    start_a = 1'b0;
    chk("E2_start_unlocked", 32'(busy_a), 32'd0);
    locked = 1'b1;
    tick;

    // F: reset mid-sweep, then a clean full sweep
    start_a = 1'b1; seed_a = 8'h00;
    tick;
    start_a = 1'b0;
    repeat (499) tick;                 // cycle 500
    chk("F_pre_err",  32'(err_a),  32'd1);
    chk("F_pre_busy", 32'(busy_a), 32'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("F_rd_en", 32'(rd_en_a),   32'd0);
    chk("F_addr",  32'(rd_addr_a), 32'd0);
    chk("F_busy",  32'(busy_a),    32'd0);
    chk("F_done",  32'(done_a),    32'd0);
    chk("F_err",   32'(err_a),     32'd0);
    chk("F_fe",    32'(fe_a),      32'd0);
    chk("F_led",   32'(led_a),     32'd0);
    repeat (5) tick;
    chk("F_no_stray", 32'(err_a), 32'd0);
    fill_a(8'h5A, -1, -1);
    sweep(0, 8'h5A, -1, cyc);
    chk("F2_cycles", 32'(cyc),    32'd1026);
    chk("F2_err",    32'(err_a),  32'd0);
    chk("F2_pass",   32'(pass_a), 32'd1);
    chk("F2_led",    32'(led_a),  32'h06);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
